shift_add_multiplier: RTL
=========================

# shift_add_multiplier

- Sequential unsigned multiplier using shift-and-add, one partial product per clock.
- Inverse companion to the team's repeated-subtraction divider; same start/`_end` handshake, so control logic drives either unit identically.
- Latches operands on `start`, iterates over multiplier bits with early termination, holds the 2N-bit product with `_end` high until the next `start`.

## Interface

Parameters:
- `N`, default 8, operand width in bits; product is 2N bits.

Ports:
- `clk`  input  1  single clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low; 0 clears all state immediately.
- `start`  input  1  request a new multiplication; sampled only in IDLE or DONE.
- `in1`  input  N  multiplicand, unsigned; sampled on the accepting edge only.
- `in2`  input  N  multiplier, unsigned; sampled on the accepting edge only.
- `product`  output  2N  accumulator contents; valid only while `_end`=1.
- `_end`  output  1  high in DONE; result valid.

## Operation

- Registers: `a` (2N, shifted multiplicand), `b` (N, shifted multiplier), `p` (2N, accumulator), state.
- Reset (reset=0, async): state=IDLE, a=b=p=0, `product`=0, `_end`=0. Takes effect mid-operation and aborts it with no partial result kept.
- States:
  - IDLE: `_end`=0. If start=1: a←zero-extended in1, b←in2, p←0; go to CALC.
  - CALC: if b==0, go to DONE with no register update. Otherwise p←p+(b[0]?a:0), a←a<<1, b←b>>1; stay. `start` is ignored.
  - DONE: `_end`=1, registers hold. If start=1, same load as IDLE and go to CALC; `_end` falls on that edge.
- Arithmetic:
  - Unsigned only. `a` is 2N wide, so no bits are lost on shift.
  - `p` never overflows because the result fits in 2N bits.
  - Additions are 2N-bit; carry out of bit 2N-1 is impossible and is discarded.
- `product` is driven directly from `p`. Intermediate values during CALC are not guaranteed meaningful.

## Timing

- Let t0 be the edge that accepts `start`, and k the bit length of in2 (0 if in2=0, N if the MSB is set).
- Cycle by cycle:
  - Edges t0+1 … t0+k perform the k accumulate steps.
  - Edge t0+k+1 observes b==0 and enters DONE.
  - `_end` is high after edge t0+k+1.
- Latency range: minimum 1 cycle (in2=0), maximum N+1 cycles.
- DONE holds indefinitely. Back-to-back: `start` held high in DONE restarts on the next edge, so `_end` is high for exactly one cycle.
- Operands may change at any time after t0 without effect.
- Reset deasserting and `start` high on the same edge: the FSM sees IDLE, and start is accepted on the first edge with reset=1.

## Structure

- Shared package holds:
  - the state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the default width constant N=8, reused by the divider bench.
- Control FSM stays in the top module.
- Datapath (`a`/`b`/`p` registers, adder, shifters, load/step controls, `b_zero` flag) is a natural sub-module: `mul_dp`, parameterised by N.
- The top passes `N` down via parameter override, matching how the divider parameterises its datapath.

## Test plan

All cases N=8.

- Reset then 13×11: start at t0 → `_end`=1 after t0+5, `product`=16'd143; `product`/`_end` 0 before start.
- 255×255 → `product`=16'hFE01, `_end` after t0+9 (max latency); 200×0 → 0 after t0+1; 0×128 → 0 after t0+9.
- Start pulsed and operands changed (in1=7, in2=9) during CALC of 6×5 → result still 30, latency unchanged.
- Reset asserted at t0+2 during 100×200 → `_end`, `product`, and state go to 0 immediately. Restart 100×200 → 20000 after t0'+9.
- Back-to-back: `start` held high with 3×3 then 4×4 → `_end` high one cycle with 9, then 16 after its own latency.
- Randomised sweep of 1000 operand pairs: each result equals in1×in2, and latency equals bit length of in2 +1.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier and its repeated-subtraction divider sibling.
package shift_add_multiplier_pkg;

  localparam int unsigned N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_dp.sv
// Multiplier datapath: shifted multiplicand, shifted multiplier and 2N-bit accumulator.
module mul_dp
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   in1,
  input  logic [N-1:0]   in2,
  output logic           b_zero,
  output logic [2*N-1:0] p
);

  logic [2*N-1:0] a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [2*N-1:0] p_q, p_d;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    if (load) begin
      a_d = {{N{1'b0}}, in1};
      b_d = in2;
      p_d = '0;
    end else if (step) begin
      // a is 2N wide, so the product always fits and the carry out can be dropped
      p_d = p_q + (b_q[0] ? a_q : '0);
      a_d = a_q << 1;
      b_d = b_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end

  assign b_zero = (b_q == '0);
  assign p      = p_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with start/_end handshake and early termination.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   in1,
  input  logic [N-1:0]   in2,
  output logic [2*N-1:0] product,
  output logic           _end
);

  state_e state_q, state_d;
  logic   load, step, b_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (b_zero) state_d = DONE;
      DONE:    if (start) state_d = CALC;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    _end = 1'b0;
    unique case (state_q)
      IDLE: load = start;
      CALC: step = !b_zero;
      DONE: begin
        load = start;
        _end = 1'b1;
      end
      default: ;
    endcase
  end

  mul_dp #(
    .N(N)
  ) u_dp (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .in1   (in1),
    .in2   (in2),
    .b_zero(b_zero),
    .p     (product)
  );

endmodule
